// File: rtl/vending_if.sv
// Coin/refund handshake between a coin mechanism (master) and the vending controller (slave).
interface vending_if #(
    parameter int unsigned CREDIT_W = 8
) ();
    logic                nickel;
    logic                dime;
    logic                quarter;
    logic                cancel;
    logic                dispense;
    logic                return5;
    logic                return10;
    logic                coin_reject;
    logic                busy;
    logic [CREDIT_W-1:0] credit;

    modport master (
        output nickel, dime, quarter, cancel,
        input  dispense, return5, return10, coin_reject, busy, credit
    );

    modport slave (
        input  nickel, dime, quarter, cancel,
        output dispense, return5, return10, coin_reject, busy, credit
    );
endinterface

// File: rtl/vending_ctrl.sv
// Coin-operated vending controller: accumulates credit, vends at PRICE, then pays change
// or refunds serially with greedy 10-cent coins followed by at most one 5-cent coin.
module vending_ctrl #(
    parameter int unsigned PRICE    = 25,
    parameter int unsigned CREDIT_W = 8
) (
    input  logic     clk,
    input  logic     reset,
    vending_if.slave bus
);

    typedef enum logic [1:0] {
        StCollect,
        StVend,
        StChange
    } state_e;

    localparam logic [CREDIT_W:0]   PriceW = (CREDIT_W + 1)'(PRICE);
    localparam logic [CREDIT_W-1:0] Five   = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] Ten    = CREDIT_W'(10);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                reject_q, reject_d;
    logic                dispense_q, return5_q, return10_q, busy_q;

    logic [CREDIT_W:0]   coin_v;
    logic [CREDIT_W:0]   sum;
    logic [CREDIT_W:0]   diff;
    logic [1:0]          n_coins;
    logic                any_coin;

    // Coin arbitration: nickel beats dime beats quarter; the losers are rejected.
    always_comb begin
        n_coins  = {1'b0, bus.nickel} + {1'b0, bus.dime} + {1'b0, bus.quarter};
        any_coin = bus.nickel | bus.dime | bus.quarter;
        coin_v   = '0;
        if (bus.nickel) begin
            coin_v = (CREDIT_W + 1)'(5);
        end else if (bus.dime) begin
            coin_v = (CREDIT_W + 1)'(10);
        end else if (bus.quarter) begin
            coin_v = (CREDIT_W + 1)'(25);
        end
        sum  = {1'b0, credit_q} + coin_v;
        diff = sum - PriceW;
    end

    // Next-state and credit update.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = 1'b0;
        unique case (state_q)
            StCollect: begin
                reject_d = (n_coins > 2'd1);
                if (bus.cancel) begin
                    credit_d = sum[CREDIT_W-1:0];
                    if (sum != '0) begin
                        state_d = StChange;
                    end
                end else if (sum >= PriceW) begin
                    credit_d = diff[CREDIT_W-1:0];
                    state_d  = StVend;
                end else begin
                    credit_d = sum[CREDIT_W-1:0];
                end
            end
            StVend: begin
                reject_d = any_coin;
                state_d  = (credit_q != '0) ? StChange : StCollect;
            end
            StChange: begin
                reject_d = any_coin;
                if (credit_q >= Ten) begin
                    credit_d = credit_q - Ten;
                end else if (credit_q >= Five) begin
                    credit_d = credit_q - Five;
                end else begin
                    credit_d = '0;
                end
                state_d = (credit_d == '0) ? StCollect : StChange;
            end
            default: begin
                state_d  = StCollect;
                credit_d = '0;
            end
        endcase
    end

    // State, credit and registered Moore outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StCollect;
            credit_q   <= '0;
            reject_q   <= 1'b0;
            dispense_q <= 1'b0;
            return5_q  <= 1'b0;
            return10_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            reject_q   <= reject_d;
            dispense_q <= (state_d == StVend);
            return10_q <= (state_d == StChange) && (credit_d >= Ten);
            return5_q  <= (state_d == StChange) && (credit_d < Ten);
            busy_q     <= (state_d != StCollect);
        end
    end

    assign bus.dispense    = dispense_q;
    assign bus.return5     = return5_q;
    assign bus.return10    = return10_q;
    assign bus.coin_reject = reject_q;
    assign bus.busy        = busy_q;
    assign bus.credit      = credit_q;

endmodule

// File: tb/tb_vending_ctrl.sv
// Self-checking bench for vending_ctrl at PRICE=25 and PRICE=60.
module tb_vending_ctrl;

    logic clk = 1'b0;
    logic rst25;
    logic rst60;

    always #5 clk = ~clk;

    vending_if #(.CREDIT_W(8)) bus25 ();
    vending_if #(.CREDIT_W(8)) bus60 ();

    vending_ctrl #(.PRICE(25), .CREDIT_W(8)) dut25 (
        .clk   (clk),
        .reset (rst25),
        .bus   (bus25)
    );

    vending_ctrl #(.PRICE(60), .CREDIT_W(8)) dut60 (
        .clk   (clk),
        .reset (rst60),
        .bus   (bus60)
    );

    // in = {nickel, dime, quarter, cancel}; fl = {dispense, return5, return10, coin_reject, busy}
    typedef struct {
        logic [3:0] in;
        logic [4:0] fl;
        int         cr;
    } vec_t;

    typedef struct {
        logic disp;
        logic r5;
        logic r10;
        int   cr;
    } busy_rec_t;

    int n_vec = 0;
    int n_bad = 0;

    vec_t vecs[$];

    // Reference model: a schedule of upcoming busy cycles, filled when a vend or refund starts.
    busy_rec_t  sched[$];
    int         m_price;
    int         m_credit;
    logic       m_busy;
    logic [4:0] m_flags;
    int         m_cr;

    function automatic vec_t mk(input logic [3:0] in, input logic [4:0] fl, input int cr);
        vec_t r;
        r.in = in;
        r.fl = fl;
        r.cr = cr;
        return r;
    endfunction

    task automatic check(input string nm, input logic [4:0] act, input int act_cr,
                         input logic [4:0] exp, input int exp_cr);
        n_vec++;
        if (act !== exp || act_cr != exp_cr) begin
            n_bad++;
            $display("FAIL %s: got flags=%b credit=%0d, want flags=%b credit=%0d",
                     nm, act, act_cr, exp, exp_cr);
        end
    endtask

    function automatic logic [4:0] flags25();
        return {bus25.dispense, bus25.return5, bus25.return10, bus25.coin_reject, bus25.busy};
    endfunction

    function automatic logic [4:0] flags60();
        return {bus60.dispense, bus60.return5, bus60.return10, bus60.coin_reject, bus60.busy};
    endfunction

    task automatic push_payout(input int amt);
        busy_rec_t r;
        int        a;
        a = amt;
        while (a > 0) begin
            r.disp = 1'b0;
            r.cr   = a;
            r.r10  = (a >= 10);
            r.r5   = (a < 10);
            sched.push_back(r);
            a -= (a >= 10) ? 10 : 5;
        end
    endtask

    task automatic model_step(input logic [3:0] in, input logic rst);
        int        v;
        int        cnt;
        int        s;
        logic      rej;
        busy_rec_t r;
        if (rst) begin
            sched.delete();
            m_credit = 0;
            m_busy   = 1'b0;
            m_flags  = '0;
            m_cr     = 0;
            return;
        end
        cnt = int'(in[3]) + int'(in[2]) + int'(in[1]);
        if (m_busy) begin
            rej = (cnt > 0);
        end else begin
            rej = (cnt > 1);
            v   = in[3] ? 5 : in[2] ? 10 : in[1] ? 25 : 0;
            s   = m_credit + v;
            if (in[0]) begin
                if (s > 0) begin
                    push_payout(s);
                    m_credit = 0;
                end
            end else if (s >= m_price) begin
                r.disp = 1'b1;
                r.r5   = 1'b0;
                r.r10  = 1'b0;
                r.cr   = s - m_price;
                sched.push_back(r);
                push_payout(s - m_price);
                m_credit = 0;
            end else begin
                m_credit = s;
            end
        end
        if (sched.size() > 0) begin
            r       = sched.pop_front();
            m_busy  = 1'b1;
            m_flags = {r.disp, r.r5, r.r10, rej, 1'b1};
            m_cr    = r.cr;
        end else begin
            m_busy  = 1'b0;
            m_flags = {3'b000, rej, 1'b0};
            m_cr    = m_credit;
        end
    endtask

    task automatic apply25(input logic [3:0] in);
        @(negedge clk);
        {bus25.nickel, bus25.dime, bus25.quarter, bus25.cancel} = in;
        @(posedge clk);
        #1;
    endtask

    task automatic apply60(input logic [3:0] in);
        @(negedge clk);
        {bus60.nickel, bus60.dime, bus60.quarter, bus60.cancel} = in;
        @(posedge clk);
        #1;
    endtask

    task automatic run_random(input int which, input int ncyc);
        logic [3:0] in;
        logic       rst;
        m_price = (which != 0) ? 60 : 25;
        for (int i = 0; i < ncyc; i++) begin
            in[3] = ($urandom_range(3) == 0);
            in[2] = ($urandom_range(3) == 0);
            in[1] = ($urandom_range(3) == 0);
            in[0] = ($urandom_range(7) == 0);
            rst   = (i == 0) || ($urandom_range(63) == 0);
            @(negedge clk);
            if (which != 0) begin
                {bus60.nickel, bus60.dime, bus60.quarter, bus60.cancel} = in;
                rst60 = rst;
            end else begin
                {bus25.nickel, bus25.dime, bus25.quarter, bus25.cancel} = in;
                rst25 = rst;
            end
            @(posedge clk);
            #1;
            model_step(in, rst);
            if (which != 0) begin
                check("rand60", flags60(), int'(bus60.credit), m_flags, m_cr);
            end else begin
                check("rand25", flags25(), int'(bus25.credit), m_flags, m_cr);
            end
        end
        @(negedge clk);
        rst25 = 1'b0;
        rst60 = 1'b0;
        {bus25.nickel, bus25.dime, bus25.quarter, bus25.cancel} = '0;
        {bus60.nickel, bus60.dime, bus60.quarter, bus60.cancel} = '0;
    endtask

    initial begin
        // Table for PRICE=25, one row per clock.
        vecs.push_back(mk(4'b0010, 5'b10001, 0));   // quarter -> vend, no change
        vecs.push_back(mk(4'b0000, 5'b00000, 0));
        vecs.push_back(mk(4'b0100, 5'b00000, 10));  // dime x3 -> vend + return5
        vecs.push_back(mk(4'b0100, 5'b00000, 20));
        vecs.push_back(mk(4'b0100, 5'b10001, 5));
        vecs.push_back(mk(4'b0000, 5'b01001, 5));
        vecs.push_back(mk(4'b0000, 5'b00000, 0));
        vecs.push_back(mk(4'b0100, 5'b00000, 10));  // dime, dime, quarter -> 2x return10
        vecs.push_back(mk(4'b0100, 5'b00000, 20));
        vecs.push_back(mk(4'b0010, 5'b10001, 20));
        vecs.push_back(mk(4'b0000, 5'b00101, 20));
        vecs.push_back(mk(4'b0000, 5'b00101, 10));
        vecs.push_back(mk(4'b0000, 5'b00000, 0));
        vecs.push_back(mk(4'b1000, 5'b00000, 5));   // nickel, dime, cancel -> refund 15
        vecs.push_back(mk(4'b0100, 5'b00000, 15));
        vecs.push_back(mk(4'b0001, 5'b00101, 15));
        vecs.push_back(mk(4'b0000, 5'b01001, 5));
        vecs.push_back(mk(4'b0000, 5'b00000, 0));
        vecs.push_back(mk(4'b0100, 5'b00000, 10));  // quarter during VEND is rejected
        vecs.push_back(mk(4'b0100, 5'b00000, 20));
        vecs.push_back(mk(4'b0100, 5'b10001, 5));
        vecs.push_back(mk(4'b0010, 5'b01011, 5));
        vecs.push_back(mk(4'b0000, 5'b00000, 0));
        vecs.push_back(mk(4'b1010, 5'b00010, 5));   // nickel+quarter -> +5, reject
        vecs.push_back(mk(4'b0000, 5'b00000, 5));
        vecs.push_back(mk(4'b0110, 5'b00010, 15));  // dime+quarter -> +10, reject
        vecs.push_back(mk(4'b0000, 5'b00000, 15));
        vecs.push_back(mk(4'b1110, 5'b00010, 20));  // all three -> +5, reject
        vecs.push_back(mk(4'b0000, 5'b00000, 20));
        vecs.push_back(mk(4'b0010, 5'b10001, 20));  // reach PRICE+20 = 45
        vecs.push_back(mk(4'b0000, 5'b00101, 20));
        vecs.push_back(mk(4'b0000, 5'b00101, 10));
        vecs.push_back(mk(4'b0000, 5'b00000, 0));
        vecs.push_back(mk(4'b0001, 5'b00000, 0));   // cancel with no credit is ignored
        vecs.push_back(mk(4'b1001, 5'b01001, 5));   // coin+cancel refunds the coin
        vecs.push_back(mk(4'b0000, 5'b00000, 0));
        vecs.push_back(mk(4'b0100, 5'b00000, 10));  // cancel during VEND is ignored
        vecs.push_back(mk(4'b0100, 5'b00000, 20));
        vecs.push_back(mk(4'b0100, 5'b10001, 5));
        vecs.push_back(mk(4'b0001, 5'b01001, 5));
        vecs.push_back(mk(4'b0000, 5'b00000, 0));

        rst25 = 1'b1;
        rst60 = 1'b1;
        {bus25.nickel, bus25.dime, bus25.quarter, bus25.cancel} = '0;
        {bus60.nickel, bus60.dime, bus60.quarter, bus60.cancel} = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset25", flags25(), int'(bus25.credit), 5'b00000, 0);
        check("reset60", flags60(), int'(bus60.credit), 5'b00000, 0);
        @(negedge clk);
        rst25 = 1'b0;
        rst60 = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply25(vecs[i].in);
            check($sformatf("vec%0d", i), flags25(), int'(bus25.credit), vecs[i].fl, vecs[i].cr);
        end

        // PRICE=60: quarter, quarter, dime -> exact vend.
        apply60(4'b0010);
        check("p60_q1", flags60(), int'(bus60.credit), 5'b00000, 25);
        apply60(4'b0010);
        check("p60_q2", flags60(), int'(bus60.credit), 5'b00000, 50);
        apply60(4'b0100);
        check("p60_vend", flags60(), int'(bus60.credit), 5'b10001, 0);
        apply60(4'b0000);
        check("p60_idle", flags60(), int'(bus60.credit), 5'b00000, 0);
        // Build 80 = PRICE+20, then reset during the 20-cent change.
        apply60(4'b0010);
        apply60(4'b0010);
        apply60(4'b1000);
        check("p60_55", flags60(), int'(bus60.credit), 5'b00000, 55);
        apply60(4'b0010);
        check("p60_vend20", flags60(), int'(bus60.credit), 5'b10001, 20);
        apply60(4'b0000);
        check("p60_chg20", flags60(), int'(bus60.credit), 5'b00101, 20);
        @(negedge clk);
        rst60 = 1'b1;
        @(posedge clk);
        #1;
        check("p60_rst", flags60(), int'(bus60.credit), 5'b00000, 0);
        @(negedge clk);
        rst60 = 1'b0;
        @(posedge clk);
        #1;
        check("p60_post", flags60(), int'(bus60.credit), 5'b00000, 0);

        run_random(0, 3000);
        run_random(1, 3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
